// File: rtl/nd_1to2_pkg.sv
// ---------------------------------------------------------------------------
// nd_1to2_pkg : shared defaults and sender-state encoding for the 1-to-2 node
// Revision    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package nd_1to2_pkg;

  localparam int NS_1to2_FSZ     = 4;
  localparam int NS_ADDRESS_SIZE = 6;
  localparam int NS_DATA_SIZE    = 4;
  localparam int NS_REDUN_SIZE   = 4;

  localparam int NUM_OUTS = 2;

  typedef enum logic [1:0] {
    SND_IDLE = 2'd0,
    SND_SEND = 2'd1,
    SND_WAIT = 2'd2
  } snd_state_t;

endpackage

`default_nettype wire

// File: rtl/nd_msg_fifo.sv
// ---------------------------------------------------------------------------
// nd_msg_fifo : power-of-two message FIFO with first-word-fall-through head
// Revision    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module nd_msg_fifo
  import nd_1to2_pkg::*;
#(
  parameter int FSZ = NS_1to2_FSZ,
  parameter int ASZ = NS_ADDRESS_SIZE,
  parameter int DSZ = NS_DATA_SIZE,
  parameter int RSZ = NS_REDUN_SIZE
) (
  input  logic           i_clk,
  input  logic           clr,
  input  logic           push,
  input  logic           pop,
  input  logic [ASZ-1:0] in_src,
  input  logic [ASZ-1:0] in_dst,
  input  logic [DSZ-1:0] in_dat,
  input  logic [RSZ-1:0] in_red,
  output logic           full,
  output logic           empty,
  output logic [ASZ-1:0] head_src,
  output logic [ASZ-1:0] head_dst,
  output logic [DSZ-1:0] head_dat,
  output logic [RSZ-1:0] head_red
);

  localparam int            PW       = $clog2(FSZ);
  localparam logic [PW:0]   FULL_CNT = (PW+1)'(FSZ);

  logic [ASZ-1:0] src_mem [FSZ];
  logic [ASZ-1:0] dst_mem [FSZ];
  logic [DSZ-1:0] dat_mem [FSZ];
  logic [RSZ-1:0] red_mem [FSZ];

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic          do_push;
  logic          do_pop;

  // Full/empty come from registered occupancy, so a pop in the same cycle
  // never makes room for a push.
  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge i_clk) begin
    if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (do_push && !clr) begin
      src_mem[wr_ptr] <= in_src;
      dst_mem[wr_ptr] <= in_dst;
      dat_mem[wr_ptr] <= in_dat;
      red_mem[wr_ptr] <= in_red;
    end
  end

  assign head_src = src_mem[rd_ptr];
  assign head_dst = dst_mem[rd_ptr];
  assign head_dat = dat_mem[rd_ptr];
  assign head_red = red_mem[rd_ptr];

endmodule

`default_nettype wire

// File: rtl/nd_1to2.sv
// ---------------------------------------------------------------------------
// nd_1to2  : routes one 4-phase message input to two outputs by destination
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module nd_1to2
  import nd_1to2_pkg::*;
#(
  parameter int FSZ   = NS_1to2_FSZ,
  parameter int ASZ   = NS_ADDRESS_SIZE,
  parameter int DSZ   = NS_DATA_SIZE,
  parameter int RSZ   = NS_REDUN_SIZE,
  parameter int PIVOT = 2**(ASZ-1)
) (
  input  logic           i_clk,
  input  logic           reset,
  output logic           ready,

  input  logic [ASZ-1:0] rcv0_src,
  input  logic [ASZ-1:0] rcv0_dst,
  input  logic [DSZ-1:0] rcv0_dat,
  input  logic [RSZ-1:0] rcv0_red,
  input  logic           rcv0_req,
  output logic           rcv0_ack,

  output logic [ASZ-1:0] snd0_src,
  output logic [ASZ-1:0] snd0_dst,
  output logic [DSZ-1:0] snd0_dat,
  output logic [RSZ-1:0] snd0_red,
  output logic           snd0_req,
  input  logic           snd0_ack,

  output logic [ASZ-1:0] snd1_src,
  output logic [ASZ-1:0] snd1_dst,
  output logic [DSZ-1:0] snd1_dat,
  output logic [RSZ-1:0] snd1_red,
  output logic           snd1_req,
  input  logic           snd1_ack
);

  localparam logic [ASZ:0] PIVOT_W = (ASZ+1)'(PIVOT);

  logic init;
  logic to_low;
  logic tgt_full;
  logic accept;

  logic [NUM_OUTS-1:0] push;
  logic [NUM_OUTS-1:0] pop;
  logic [NUM_OUTS-1:0] full;
  logic [NUM_OUTS-1:0] empty;
  logic [NUM_OUTS-1:0] out_ack;

  logic [ASZ-1:0] head_src [NUM_OUTS];
  logic [ASZ-1:0] head_dst [NUM_OUTS];
  logic [DSZ-1:0] head_dat [NUM_OUTS];
  logic [RSZ-1:0] head_red [NUM_OUTS];

  logic [ASZ-1:0] out_src  [NUM_OUTS];
  logic [ASZ-1:0] out_dst  [NUM_OUTS];
  logic [DSZ-1:0] out_dat  [NUM_OUTS];
  logic [RSZ-1:0] out_red  [NUM_OUTS];

  snd_state_t state [NUM_OUTS];
  snd_state_t nxt   [NUM_OUTS];

  // ready rises on the first edge out of reset; that same edge clears all state.
  always_ff @(posedge i_clk) begin
    if (reset) ready <= 1'b0;
    else       ready <= 1'b1;
  end

  assign init = reset | ~ready;

  // Input side: route by destination, stall while the chosen FIFO is full.
  assign to_low   = ({1'b0, rcv0_dst} < PIVOT_W);
  assign tgt_full = to_low ? full[0] : full[1];
  assign accept   = ~init & rcv0_req & ~rcv0_ack & ~tgt_full;
  assign push[0]  = accept & to_low;
  assign push[1]  = accept & ~to_low;

  always_ff @(posedge i_clk) begin
    if (init)                        rcv0_ack <= 1'b0;
    else if (accept)                 rcv0_ack <= 1'b1;
    else if (rcv0_ack && !rcv0_req)  rcv0_ack <= 1'b0;
  end

  nd_msg_fifo #(.FSZ(FSZ), .ASZ(ASZ), .DSZ(DSZ), .RSZ(RSZ)) u_fifo0 (
    .i_clk    (i_clk),
    .clr      (init),
    .push     (push[0]),
    .pop      (pop[0]),
    .in_src   (rcv0_src),
    .in_dst   (rcv0_dst),
    .in_dat   (rcv0_dat),
    .in_red   (rcv0_red),
    .full     (full[0]),
    .empty    (empty[0]),
    .head_src (head_src[0]),
    .head_dst (head_dst[0]),
    .head_dat (head_dat[0]),
    .head_red (head_red[0])
  );

  nd_msg_fifo #(.FSZ(FSZ), .ASZ(ASZ), .DSZ(DSZ), .RSZ(RSZ)) u_fifo1 (
    .i_clk    (i_clk),
    .clr      (init),
    .push     (push[1]),
    .pop      (pop[1]),
    .in_src   (rcv0_src),
    .in_dst   (rcv0_dst),
    .in_dat   (rcv0_dat),
    .in_red   (rcv0_red),
    .full     (full[1]),
    .empty    (empty[1]),
    .head_src (head_src[1]),
    .head_dst (head_dst[1]),
    .head_dat (head_dat[1]),
    .head_red (head_red[1])
  );

  assign out_ack = {snd1_ack, snd0_ack};

  // Output sequencers: the WAIT state guarantees a full ack cycle completes
  // before the next load, so a reload can never overlap a live request.
  always_comb begin
    for (int i = 0; i < NUM_OUTS; i++) begin
      nxt[i] = state[i];
      pop[i] = 1'b0;
      if (!init) begin
        case (state[i])
          SND_IDLE: begin
            if (!empty[i]) begin
              nxt[i] = SND_SEND;
              pop[i] = 1'b1;
            end
          end
          SND_SEND: if (out_ack[i])  nxt[i] = SND_WAIT;
          SND_WAIT: if (!out_ack[i]) nxt[i] = SND_IDLE;
          default:  nxt[i] = SND_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge i_clk) begin
    for (int i = 0; i < NUM_OUTS; i++) begin
      if (init) begin
        state[i]   <= SND_IDLE;
        out_src[i] <= '0;
        out_dst[i] <= '0;
        out_dat[i] <= '0;
        out_red[i] <= '0;
      end else begin
        state[i] <= nxt[i];
        if (pop[i]) begin
          out_src[i] <= head_src[i];
          out_dst[i] <= head_dst[i];
          out_dat[i] <= head_dat[i];
          out_red[i] <= head_red[i];
        end
      end
    end
  end

  assign snd0_req = (state[0] == SND_SEND);
  assign snd0_src = out_src[0];
  assign snd0_dst = out_dst[0];
  assign snd0_dat = out_dat[0];
  assign snd0_red = out_red[0];

  assign snd1_req = (state[1] == SND_SEND);
  assign snd1_src = out_src[1];
  assign snd1_dst = out_dst[1];
  assign snd1_dat = out_dat[1];
  assign snd1_red = out_red[1];

endmodule

`default_nettype wire
